// File: rtl/out_arb_pkg.sv
// Shared types and helpers for the round-robin host-channel arbiter.
// Header framing is enabled by defining OUT_ARB_HDR_EN.
package out_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        LOAD,
        SEND
    } arb_state_e;

    localparam int unsigned MAX_W = 64;
    localparam logic HDR_FLAG = 1'b1;

    // MSB marker plus the source index in the low bits.
    function automatic logic [MAX_W-1:0] hdr_word(
        input int unsigned idx,
        input int unsigned data_w
    );
        logic [MAX_W-1:0] w;
        w = MAX_W'(idx);
        w[data_w-1] = HDR_FLAG;
        return w;
    endfunction

endpackage

// File: rtl/out_arbiter_rr_pick.sv
// Rotating-priority encoder: first requester strictly after last_idx.
// Pure combinational helper for out_arbiter.
module rr_pick #(
    parameter int N_SRCS = 2,
    parameter int IDX_W  = 1
) (
    input  logic [N_SRCS-1:0] req,
    input  logic [IDX_W-1:0]  last_idx,
    output logic [IDX_W-1:0]  winner_idx,
    output logic              valid
);

    logic [IDX_W:0] pos;

    // Walk from furthest to nearest so the nearest requester wins.
    always_comb begin
        valid      = 1'b0;
        winner_idx = '0;
        pos        = '0;
        for (int i = N_SRCS; i >= 1; i--) begin
            pos = {1'b0, last_idx} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(N_SRCS)) begin
                pos = pos - (IDX_W+1)'(N_SRCS);
            end
            if (req[pos[IDX_W-1:0]]) begin
                valid      = 1'b1;
                winner_idx = pos[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/out_arbiter.sv
// Round-robin merge of N_SRCS word streams onto the host out channel.
// Define OUT_ARB_HDR_EN to prefix every grant with a header word.
module out_arbiter
    import out_arb_pkg::*;
#(
    parameter int N_SRCS    = 2,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                     clk_i,
    input  logic                     nreset_i,
    input  logic [N_SRCS*DATA_W-1:0] src_data_i,
    input  logic [N_SRCS-1:0]        src_req_i,
    output logic [N_SRCS-1:0]        src_ack_o,
    output logic [N_SRCS-1:0]        grant_o,
    output logic [DATA_W-1:0]        out_data_o,
    output logic                     out_req_o,
    input  logic                     out_ack_i
);

    localparam int IDX_W = (N_SRCS > 1) ? $clog2(N_SRCS) : 1;
    localparam int BW    = $clog2(MAX_BURST + 1);

    generate
        if (N_SRCS < 1 || MAX_BURST < 1) begin : g_bad_size
            $fatal(1, "out_arbiter: N_SRCS and MAX_BURST must be >= 1");
        end
        if (DATA_W <= $clog2(N_SRCS) || DATA_W > int'(MAX_W)) begin : g_bad_w
            $fatal(1, "out_arbiter: DATA_W must exceed clog2(N_SRCS)");
        end
    endgenerate

    arb_state_e        state;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  last_idx;
    logic [IDX_W-1:0]  winner_idx;
    logic              winner_valid;
    logic [BW-1:0]     burst_cnt;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] slice;
    logic [N_SRCS-1:0] grant_oh;

    rr_pick #(
        .N_SRCS (N_SRCS),
        .IDX_W  (IDX_W)
    ) u_pick (
        .req        (src_req_i),
        .last_idx   (last_idx),
        .winner_idx (winner_idx),
        .valid      (winner_valid)
    );

    assign slice    = src_data_i[32'(grant_idx) * DATA_W +: DATA_W];
    assign grant_oh = N_SRCS'(1) << grant_idx;

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state      <= IDLE;
            grant_idx  <= '0;
            last_idx   <= IDX_W'(N_SRCS - 1);
            burst_cnt  <= '0;
            out_data_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (winner_valid) begin
                        grant_idx <= winner_idx;
                        burst_cnt <= '0;
`ifdef OUT_ARB_HDR_EN
                        state     <= HDR;
`else
                        state     <= LOAD;
`endif
                    end
                end
`ifdef OUT_ARB_HDR_EN
                HDR: begin
                    out_data_q <= DATA_W'(hdr_word(32'(grant_idx), DATA_W));
                    state      <= SEND;
                end
`endif
                LOAD: begin
                    if (src_req_i[grant_idx]) begin
                        out_data_q <= slice;
                        burst_cnt  <= burst_cnt + 1'b1;
                        state      <= SEND;
                    end else begin
                        last_idx <= grant_idx;
                        state    <= IDLE;
                    end
                end
                SEND: begin
                    // A header leaves burst_cnt untouched, so it always reloads.
                    if (out_ack_i) begin
                        if (burst_cnt == BW'(MAX_BURST)) begin
                            last_idx <= grant_idx;
                            state    <= IDLE;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_req_o  = (state == SEND);
    assign out_data_o = out_data_q;
    assign grant_o    = (state != IDLE) ? grant_oh : '0;
    assign src_ack_o  = (state == LOAD && src_req_i[grant_idx]) ? grant_oh : '0;

endmodule
